// File: rtl/core_block_ctrl.sv
// core_block_ctrl: per-core responder to block dispatch; runs FETCH..UPDATE per instruction until RET.
// Latency: start accepted at edge N -> fetch_req in cycle N+1; 6 cycles/instruction unstalled; core_done one cycle after entering DONE.
// Backpressure: FETCH holds until fetch_ack; WAIT holds while any enabled thread's LSU is busy.
//
// Ports:
//   clk, reset_n         clock, async active-low hard reset
//   core_reset           sync soft reset from dispatch (dominates core_start)
//   core_start           block assignment valid; block_id / thread_count sampled with it
//   core_done            block finished, held until core_reset
//   block_id_q           latched block index
//   thread_enable        active-thread mask
//   fetch_req/addr/ack/instr  instruction fetch handshake
//   instruction          latched current instruction word
//   decoded_ret          decoder flag: current instruction is RET
//   lsu_busy             per-thread outstanding LSU request
//   next_pc, pc          PC unit result, current PC
//   stage                FSM state broadcast to ALU/LSU/PC units
module core_block_ctrl #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int INSTR_BITS        = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 core_reset,
  input  logic                                 core_start,
  input  logic [7:0]                           block_id,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  output logic                                 core_done,
  output logic [7:0]                           block_id_q,
  output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
  output logic                                 fetch_req,
  output logic [PC_BITS-1:0]                   fetch_addr,
  input  logic                                 fetch_ack,
  input  logic [INSTR_BITS-1:0]                fetch_instr,
  output logic [INSTR_BITS-1:0]                instruction,
  input  logic                                 decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]         lsu_busy,
  input  logic [PC_BITS-1:0]                   next_pc,
  output logic [PC_BITS-1:0]                   pc,
  output logic [2:0]                           stage
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [THREADS_PER_BLOCK-1:0] start_mask;

  // Thermometer mask of the low min(thread_count, THREADS_PER_BLOCK) bits;
  // counts above the core width saturate to all threads enabled.
  always_comb begin
    start_mask = '0;
    for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
      start_mask[t] = (int'(thread_count) > t);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (core_reset) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_start) begin
            state_nxt = (thread_count == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            state_nxt = S_DECODE;
          end
        end
        S_DECODE:  state_nxt = S_REQUEST;
        S_REQUEST: state_nxt = S_WAIT;
        S_WAIT: begin
          // Only enabled threads can hold the core in WAIT.
          if (!(|(lsu_busy & thread_enable))) begin
            state_nxt = S_EXECUTE;
          end
        end
        S_EXECUTE: state_nxt = S_UPDATE;
        S_UPDATE:  state_nxt = decoded_ret ? S_DONE : S_FETCH;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_done     <= 1'b0;
      block_id_q    <= '0;
      thread_enable <= '0;
      instruction   <= '0;
      pc            <= '0;
    end else if (core_reset) begin
      core_done     <= 1'b0;
      thread_enable <= '0;
      pc            <= '0;
    end else begin
      // Registered from state so it rises the cycle after DONE is entered.
      core_done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (core_start) begin
            block_id_q    <= block_id;
            thread_enable <= start_mask;
            pc            <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            instruction <= fetch_instr;
          end
        end
        S_UPDATE: begin
          // RET leaves pc pointing at itself.
          if (!decoded_ret) begin
            pc <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_req  = (state == S_FETCH);
  assign fetch_addr = pc;
  assign stage      = state;

endmodule

// File: doc/core_block_ctrl.md
Name: core_block_ctrl

Overview:
- Core-side responder to the top-level block dispatch handshake: one instance per compute core.
- Accepts a block assignment (start, block id, thread count) and latches it.
- Sequences the core's per-instruction pipeline through fetch, decode, memory request/wait, execute and PC update.
- Raises core_done when the kernel's RET retires and holds it until the dispatcher recycles the core with core_reset.

Parameters:
- THREADS_PER_BLOCK, 4, threads per core; width of enable/busy masks.
- PC_BITS, 8, program counter width.
- INSTR_BITS, 16, instruction word width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low hard reset
- core_reset  in  1  synchronous active-high soft reset from dispatch; dominates core_start
- core_start  in  1  block assignment valid from dispatch
- block_id  in  8  block index, sampled at accept
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads in block, sampled at accept
- core_done  out  1  block finished; held until core_reset
- block_id_q  out  8  latched block index
- thread_enable  out  THREADS_PER_BLOCK  active-thread mask
- fetch_req  out  1  instruction fetch request
- fetch_addr  out  PC_BITS  fetch address (= pc)
- fetch_ack  in  1  fetch complete; fetch_instr valid this cycle
- fetch_instr  in  INSTR_BITS  fetched word
- instruction  out  INSTR_BITS  latched current instruction, to decoder
- decoded_ret  in  1  decoder: current instruction is RET
- lsu_busy  in  THREADS_PER_BLOCK  per-thread LSU request outstanding
- next_pc  in  PC_BITS  next PC from the PC unit (threads convergent)
- pc  out  PC_BITS  current program counter
- stage  out  3  FSM state encoding, broadcast to the ALU, LSU and PC units

Behaviour:
- reset_n low (async): state IDLE. core_done, fetch_req, thread_enable, block_id_q, instruction and pc all 0. stage=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- core_reset high at any clock edge (any state):
  - next state IDLE; core_done, fetch_req and thread_enable cleared; pc=0.
  - core_start in the same cycle is ignored.
- IDLE: on core_start & !core_reset:
  - latch block_id_q=block_id and pc=0.
  - thread_enable = low min(thread_count, THREADS_PER_BLOCK) bits set.
  - next state FETCH; if thread_count==0, next state DONE instead.
- FETCH:
  - fetch_req=1 combinationally, fetch_addr=pc.
  - On fetch_ack: instruction<=fetch_instr, fetch_req drops the next cycle, go DECODE.
  - fetch_ack outside FETCH is ignored.
- DECODE: 1 cycle -> REQUEST.
- REQUEST: 1 cycle (LSUs issue) -> WAIT.
- WAIT: stay while |(lsu_busy & thread_enable); else -> EXECUTE. Busy bits of disabled threads are ignored.
- EXECUTE: 1 cycle -> UPDATE.
- UPDATE:
  - decoded_ret=1: go DONE; pc unchanged.
  - else: pc<=next_pc, go FETCH. PC wraps modulo 2^PC_BITS.
- DONE:
  - core_done=1 (registered; first asserted the cycle after leaving UPDATE).
  - Stays until core_reset. core_start ignored.
  - thread_enable and block_id_q hold their values.
- Latency:
  - core_start accepted at edge N -> fetch_req high in cycle N+1.
  - With immediate fetch_ack and no LSU busy, each instruction takes 6 cycles (FETCH..UPDATE).
- Output timing: all outputs registered except fetch_req, fetch_addr and stage, which decode from state/pc registers only (no input-to-output combinational path).

Test Plan:
- Reset: pulse reset_n low mid-FETCH, asynchronously -> fetch_req drops immediately; state IDLE, pc=0, core_done=0.
- Single block: block_id=5, thread_count=3; program is one non-RET instruction (next_pc=1) then RET; fetch_ack immediate; lsu_busy=0.
  - Required: thread_enable=0b0111, block_id_q=5.
  - fetch_addr sequence 0 then 1.
  - core_done rises exactly 13 cycles after the start edge and holds.
- LSU stall: lsu_busy=0b0010 for 4 cycles in WAIT with enable 0b1111 -> stays in WAIT (stage=4) for 4 extra cycles, then EXECUTE.
  - With enable 0b0001 and the same busy pattern -> no stall.
- Fetch backpressure: fetch_ack delayed 3 cycles -> fetch_req held 4 cycles at a stable fetch_addr. A spurious fetch_ack during WAIT has no effect.
- Recycle: in DONE, core_reset=1 together with core_start=1 -> IDLE, core_done=0, start ignored.
  - Next cycle, core_start with block_id=9, thread_count=4 -> accepted, thread_enable=0b1111.
- Boundaries:
  - thread_count=0 -> DONE without any fetch_req.
  - thread_count=7 with THREADS_PER_BLOCK=4 -> enable clamped to 0b1111.
  - next_pc=0xFF then 0x00 -> pc wraps.
